// File: rtl/alu_seq.sv
// alu_seq: registered W-bit ALU with NZVC flag register, SUB/ADC and
// bit-serial shifts, with valid/ready handshakes on both sides.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, op, cin;
//        out_valid/out_ready with res and flag outputs n, z, v, c.
module alu_seq #(
    parameter  int W  = 8,
    localparam int SW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res,
    output logic         n,
    output logic         z,
    output logic         v,
    output logic         c
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_ADC = 3'b101;

    state_t        state_q, state_d;
    logic [W-1:0]  res_q, res_d;
    logic [3:0]    flg_q, flg_d;   // {N,Z,V,C}
    logic [W-1:0]  sh_q, sh_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;   // 1: arithmetic right

    logic [SW-1:0] k;
    logic [W:0]    addend_b;
    logic          cy_in;
    logic [W:0]    sum;
    logic [W-1:0]  r;
    logic          rv;
    logic          rc;
    logic [W-1:0]  step;
    logic          step_out;
    logic          accept;
    logic          is_shift;

    assign k         = b[SW-1:0];
    assign is_shift  = (op[2:1] == 2'b11);
    assign out_valid = (state_q == DONE);
    assign in_ready  = !rst && ((state_q == IDLE) ||
                                ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;

    assign res = res_q;
    assign n   = flg_q[3];
    assign z   = flg_q[2];
    assign v   = flg_q[1];
    assign c   = flg_q[0];

    // Single W+1-bit adder shared by ADD, SUB and ADC.
    always_comb begin
        addend_b = {1'b0, b};
        cy_in    = cin;
        if (op == OP_SUB) begin
            addend_b = {1'b0, ~b};
            cy_in    = 1'b1;
        end else if (op == OP_ADC) begin
            cy_in = flg_q[0];
        end
        sum = {1'b0, a} + addend_b + {{W{1'b0}}, cy_in};
    end

    // Single-cycle result; shifts land here only when k == 0.
    always_comb begin
        r  = a;
        rv = 1'b0;
        rc = 1'b0;
        unique case (op)
            OP_ADD, OP_ADC: begin
                r  = sum[W-1:0];
                rc = sum[W];
                rv = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                r  = sum[W-1:0];
                rc = sum[W];
                rv = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: r = a;
        endcase
    end

    always_comb begin
        if (dir_q) begin
            step     = {sh_q[W-1], sh_q[W-1:1]};
            step_out = sh_q[0];
        end else begin
            step     = {sh_q[W-2:0], 1'b0};
            step_out = sh_q[W-1];
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        flg_d   = flg_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE, DONE: begin
                if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    if (is_shift && (k != '0)) begin
                        sh_d    = a;
                        cnt_d   = k;
                        dir_d   = op[0];
                        state_d = SHIFT;
                    end else begin
                        res_d   = r;
                        flg_d   = {r[W-1], (r == '0), rv, rc};
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                sh_d  = step;
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    res_d   = step;
                    flg_d   = {step[W-1], (step == '0), 1'b0, step_out};
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            flg_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised ALU with valid/ready handshakes on input and output, a stored NZVC flag register and two extra arithmetic ops, SUB and ADC (add using the stored carry). It also has multi-cycle bit-serial shifts, one bit per cycle. It extends the combinational W-bit ALU (ADD/AND/OR/XOR, N/Z/V/carry) for multi-word arithmetic in the datapath, and sits between an operand source and a result consumer.

## Interface
- W, 8: operand/result width; power of two, ≥4.
- SW, $clog2(W): shift-amount width (derived; do not override).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op valid.
- in_ready  out  1  block can accept; transfer on in_valid & in_ready at a rising edge.
- a  in  W  operand A (two's complement).
- b  in  W  operand B; for shifts, b[SW-1:0] is the shift count k.
- op  in  3  000 ADD, 001 AND, 010 OR, 011 XOR, 100 SUB, 101 ADC, 110 SHL (logical), 111 SHR (arithmetic).
- cin  in  1  carry-in; used by ADD only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts; transfer on out_valid & out_ready at a rising edge.
- res  out  W  result.
- n, z, v, c  out  1 each  flags of res: negative, zero, signed overflow, carry.

## Operation
- States: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On accept:
    - op 000–101 or shift with k=0: compute and register res/flags, go to DONE.
    - Shift with k>0: load shift register=a and count=k, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle, shift 1 bit and decrement count. The last shift (count==1) registers res/flags and goes to DONE.
  - DONE: out_valid=1, in_ready=out_ready.
    - On out_ready with no new accept: go to IDLE.
    - On out_ready with a simultaneous accept: behave as the IDLE accept (back-to-back, one non-shift result per cycle).
- Arithmetic: {c,res} is computed at W+1 bits.
  - ADD: a+b+cin.
  - SUB: a+~b+1; c=1 means no borrow.
  - ADC: a+b+C, where C is the stored flag register carry; cin is ignored.
  - ADD/ADC: v = (a[W-1]==b[W-1]) & (res[W-1]!=a[W-1]).
  - SUB: v = (a[W-1]!=b[W-1]) & (res[W-1]!=a[W-1]).
- Logic ops (AND/OR/XOR): c=0, v=0.
- Shifts:
  - SHL inserts 0 at bit 0. SHR replicates a[W-1].
  - c is the last bit shifted out (0 when k=0). v=0.
  - k=0 returns a.
- All ops: n=res[W-1], z=(res==0).
- Flag register {N,Z,V,C} is updated with each result when the result is registered, not when it is consumed. The outputs n/z/v/c show the flag register.
- res and flags hold stable while out_valid & !out_ready.

## Timing
- Reset values: state IDLE, out_valid=0, res=0, n=z=v=c=0, flag register 0. in_ready=0 while rst is high and 1 in the first cycle after rst is released.
- Latency, counting from the accepting edge E0:
  - Non-shift ops and shift with k=0: out_valid is high after E0.
  - Shift with k≥1: out_valid is high after edge Ek, i.e. k cycles of SHIFT with in_ready=0.
- Max shift latency is W-1 cycles. in_ready is never high in SHIFT.
- ADC issued back-to-back after ADD uses that ADD's carry (the flag register is already updated at E0 of the ADD).
- rst asserted in any state, including mid-shift or in DONE under backpressure:
  - the operation is aborted and no result is produced;
  - reset values apply at the next edge.
- in_valid while in_ready=0 is ignored, and the inputs are not sampled.

## Test plan
- ADD, W=8: a=0x7F, b=0x01, cin=0 → res=0x80, n=1 z=0 v=1 c=0, out_valid after E0. With cin=1, a=0xFF, b=0x00 → res=0x00, z=1 c=1 v=0.
- SUB: a=0x00, b=0x01 → res=0xFF, c=0, n=1, v=0. Then a=0x80, b=0x01 → res=0x7F, v=1, c=1.
- Multi-word: ADD a=0xFF, b=0x01 (c=1, res=0x00) back-to-back with ADC a=0x00, b=0x00 → res=0x01, c=0. Check one result per cycle with out_ready held 1.
- Shifts:
  - SHL a=0x81, k=3 → res=0x08, c=0, out_valid 3 cycles after accept, in_ready=0 throughout.
  - SHR a=0x90, k=4 → res=0xF9, c=0.
  - SHL k=0 → res=a, c=0, single-cycle.
- Backpressure: hold out_ready=0 for 5 cycles after an XOR result → res/flags stable, in_ready=0, extra in_valid not accepted. Release → one transfer only.
- Reset: assert rst during SHIFT (k=7, after 3 shifts) → next cycle out_valid=0, flags=0, C=0. A following ADC of 0x00+0x00 gives res=0x00.
